// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch controller:
//   - controller state encoding (IDLE / RUN / HALT)
//   - fault codes reported on the Fault output
//   - the NOP word used to fill IF/ID bubbles
//   - a small word-alignment helper
package fetch_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_HALT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN,
        HALT = STATE_HALT
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_RANGE = 2'b01;
    localparam logic [1:0] FAULT_ALIGN = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // True when the two low address bits select a whole word.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// if_id_register
// IF/ID pipeline register holding the fetched instruction, its PC+4 and a
// valid flag.
//   clk         in   clock
//   srst        in   synchronous active-high reset (clears everything)
//   load        in   capture instr_in / pc_plus4_in, mark valid
//   bubble      in   insert a NOP: instruction cleared, valid cleared,
//                    pc_plus4 left as it was (wins over load)
//   instr_in    in   instruction word to capture
//   pc_plus4_in in   PC+4 of that instruction
//   instruction out  registered instruction
//   pc_plus4    out  registered PC+4
//   valid       out  register holds a real instruction
// With neither load nor bubble the register holds its contents.
module if_id_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instruction_reg;
    logic [31:0] pc_plus4_reg;
    logic        valid_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            instruction_reg <= NOP_WORD;
            pc_plus4_reg    <= 32'h0000_0000;
            valid_reg       <= 1'b0;
        end else if (bubble) begin
            instruction_reg <= NOP_WORD;
            valid_reg       <= 1'b0;
        end else if (load) begin
            instruction_reg <= instr_in;
            pc_plus4_reg    <= pc_plus4_in;
            valid_reg       <= 1'b1;
        end
    end

    assign instruction = instruction_reg;
    assign pc_plus4    = pc_plus4_reg;
    assign valid       = valid_reg;

endmodule

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller
// Owns the program counter, presents it to a combinational instruction
// memory and registers the returned word into the IF/ID register. Handles
// start, stall, branch redirect and fault halting.
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   DEPTH     instruction memory size in words; fetches at >= DEPTH*4 fault
// Ports:
//   Clk              in   clock
//   Rst              in   synchronous active-high reset, highest priority
//   Start            in   leave IDLE and begin fetching
//   Stall            in   hold PC, IF/ID and FetchCount
//   BranchTaken      in   redirect fetch to BranchTarget (overrides Stall)
//   BranchTarget     in   redirect byte address
//   IMemAddress      out  byte address to instruction memory (= PC)
//   IMemInstruction  in   word returned for IMemAddress
//   Instruction      out  IF/ID instruction
//   PCPlus4          out  IF/ID PC+4
//   Valid            out  IF/ID holds a real instruction
//   Halted           out  controller is in HALT
//   Fault            out  00 none, 01 fetch out of range, 10 misaligned branch
//   FetchCount       out  instructions issued into IF/ID (wraps)
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid,
    output logic        Halted,
    output logic [1:0]  Fault,
    output logic [31:0] FetchCount
);

    // First byte address past the end of the instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(DEPTH) << 2;

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [1:0]   fault_reg, fault_next;
    logic [31:0]  fetch_count_reg, fetch_count_next;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            fault_reg       <= FAULT_NONE;
            fetch_count_reg <= 32'h0000_0000;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fault_reg       <= fault_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fault_next       = fault_reg;
        fetch_count_next = fetch_count_reg;
        ifid_load        = 1'b0;
        ifid_bubble      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (BranchTaken) begin
                    // A misaligned target is never loaded; PC keeps the value
                    // that issued the bad branch so it can be inspected.
                    ifid_bubble = 1'b1;
                    if (!is_word_aligned(BranchTarget[1:0])) begin
                        state_next = HALT;
                        fault_next = FAULT_ALIGN;
                    end else begin
                        pc_next = BranchTarget;
                    end
                end else if (Stall) begin
                    // Everything holds.
                end else if (pc_reg >= PC_LIMIT) begin
                    // Range is checked only for the PC being fetched, so a
                    // branch can still rescue an out-of-range PC.
                    state_next  = HALT;
                    fault_next  = FAULT_RANGE;
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_load        = 1'b1;
                    pc_next          = pc_plus4;
                    fetch_count_next = fetch_count_reg + 32'd1;
                end
            end

            HALT: begin
                // Only Rst leaves HALT.
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    if_id_register u_if_id (
        .clk         (Clk),
        .srst        (Rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_in    (IMemInstruction),
        .pc_plus4_in (pc_plus4),
        .instruction (Instruction),
        .pc_plus4    (PCPlus4),
        .valid       (Valid)
    );

    assign IMemAddress = pc_reg;
    assign Halted      = (state_reg == HALT);
    assign Fault       = fault_reg;
    assign FetchCount  = fetch_count_reg;

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the MIPS instruction memory. Owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Handles start, stall, branch redirect and fault halting on behalf of the decode/execute stages. Sits between the instruction memory and the decode stage; the memory stays a pure read-only lookup.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned
- DEPTH, 128: instruction memory size in words; fetch addresses at or above DEPTH*4 fault

- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; leaves IDLE and begins fetching
- Stall  in  1  hold PC and IF/ID contents
- BranchTaken  in  1  redirect fetch to BranchTarget this cycle
- BranchTarget  in  32  redirect address (byte address)
- IMemAddress  out  32  byte address to instruction memory (= PC)
- IMemInstruction  in  32  word returned combinationally for IMemAddress
- Instruction  out  32  IF/ID instruction register
- PCPlus4  out  32  IF/ID PC+4 of that instruction
- Valid  out  1  IF/ID holds a real instruction
- Halted  out  1  controller in HALT state
- Fault  out  2  2'b00 none, 2'b01 fetch out of range, 2'b10 misaligned branch target
- FetchCount  out  32  number of instructions issued into IF/ID

## Operation
- States: IDLE, RUN, HALT.
- Reset: state IDLE. PC=RESET_PC. Instruction=0, PCPlus4=0, Valid=0, Halted=0, Fault=0, FetchCount=0. Rst has priority over every other input.
- IDLE: PC held, Valid=0. On Start, go to RUN. The first fetch occurs on the edge after RUN is entered.
- RUN, per-cycle priority:
  1. BranchTaken:
     - If BranchTarget[1:0]!=0: go to HALT, Fault=2'b10.
     - Otherwise: PC<=BranchTarget; IF/ID <= bubble (Instruction=0, Valid=0, PCPlus4 unchanged).
     - BranchTaken overrides Stall.
  2. Stall: PC, IF/ID and FetchCount hold.
  3. PC >= DEPTH*4: go to HALT, Fault=2'b01; IF/ID <= bubble.
  4. Normal: Instruction<=IMemInstruction, PCPlus4<=PC+4, Valid<=1, PC<=PC+4, FetchCount<=FetchCount+1.
- HALT:
  - Halted=1, Valid=0, PC frozen at the faulting value (misaligned target is not loaded).
  - Start is ignored; only Rst exits HALT.
- Arithmetic and widths:
  - PC arithmetic is 32-bit unsigned with wrap-around. Wrap never matters in practice because the range check faults first.
  - IMemAddress=PC always; the memory indexes with Address[31:2].
  - FetchCount wraps modulo 2^32.
- Start while in RUN: no effect.

## Timing
- Fetch latency: instruction at PC appears on Instruction/Valid one cycle after PC is presented.
- Throughput: one instruction per cycle when not stalled.
- Branch penalty: one bubble cycle. The target instruction is valid two edges after the BranchTaken cycle.
- Stall is sampled each edge; it may stay asserted indefinitely with no loss of data.
- Reset asserted mid-run: outputs take reset values on the same edge; any in-flight IF/ID content is discarded.
- Simultaneous BranchTaken and Stall: the branch wins and a bubble is inserted.
- Simultaneous BranchTaken with PC out of range: the branch is taken; a range fault applies only to the PC actually fetched.

## Structure
- Shared package `fetch_pkg`:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, HALT=2'd2)
  - fault codes FAULT_NONE/FAULT_RANGE/FAULT_ALIGN
  - NOP word 32'h0000_0000
- Sub-module `if_id_register`: holds Instruction/PCPlus4/Valid, with load, bubble and hold controls.
- PC, state machine and counter live in the top module.
- The instruction memory is instantiated outside this block.

## Test plan
- Sequential fetch:
  - Stimulus: reset; Start; memory[i]=i*4; run 5 cycles.
  - Required: Instruction sequence 0,4,8,12,16; PCPlus4 4..20; FetchCount=5; Valid=1 from the second cycle after Start.
- Stall:
  - Stimulus: Stall held 3 cycles at PC=8.
  - Required: IMemAddress stays 8; Instruction/PCPlus4/FetchCount unchanged. Fetch resumes with word at 8 on the first edge after Stall drops.
- Branch with stall:
  - Stimulus: BranchTaken=1, BranchTarget=32'h40, Stall=1 in the same cycle.
  - Required: next cycle PC=32'h40, Valid=0; following cycle Instruction=memory[16], PCPlus4=32'h44.
- Misaligned target:
  - Stimulus: BranchTaken with BranchTarget=32'h22.
  - Required: next cycle Halted=1, Fault=2'b10, PC unchanged, Valid=0; Start ignored afterwards.
- Range fault with DEPTH=4:
  - Stimulus: run from 0.
  - Required: four valid fetches, then Halted=1, Fault=2'b01, IMemAddress=32'h10, FetchCount=4.
- Reset mid-run:
  - Stimulus: Rst during RUN at PC=32'h1C.
  - Required: next cycle PC=RESET_PC, state IDLE, Valid=0, FetchCount=0, Fault=0.
